sdi_rx_trs_decoder: RTL and testbench

//  Receive-side counterpart of the SD-SDI transmit path.
//  - Accepts the deserialised 10-bit SD-SDI word stream (one word per rx_ce).
//  - Detects TRS sequences (3FF 000 000 XYZ) and checks XYZ protection bits.
//  - Regenerates F/V/H timing, sample/line counters and a line-length lock flag for downstream video logic.

---
 rtl/sdi_rx_trs_decoder.sv | 220 ++++++++++++++++++++++
 tb/tb_sdi_rx_trs_decoder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdi_rx_trs_decoder.sv
// SD-SDI receive TRS decoder: word pipeline, XYZ check, F/V/H regeneration,
// sample/line counters and line-length lock.
module sdi_rx_trs_decoder #(
    parameter int SAMPLES_PER_LINE = 1716,
    parameter int LOCK_LINES       = 4,
    parameter int UNLOCK_ERRS      = 3
) (
    input  logic        sdi_rx_clk,
    input  logic        sdi_rx_rst,
    input  logic        rx_ce,
    input  logic [9:0]  rx_data,
    output logic        vid_ce,
    output logic [9:0]  vid_data,
    output logic        vid_trs,
    output logic        vid_eav,
    output logic        vid_field,
    output logic        vid_vblank,
    output logic        vid_hblank,
    output logic        vid_active,
    output logic [11:0] sample_cnt,
    output logic [10:0] line_cnt,
    output logic        locked,
    output logic        trs_prot_err,
    output logic [15:0] prot_err_count
);

    localparam int GW = $clog2(LOCK_LINES) + 1;
    localparam int EW = $clog2(UNLOCK_ERRS) + 1;
    localparam logic [11:0]   LAST_SAMPLE = 12'(SAMPLES_PER_LINE - 1);
    localparam logic [GW-1:0] GOOD_LAST   = GW'(LOCK_LINES - 1);
    localparam logic [EW-1:0] ERRS_LAST   = EW'(UNLOCK_ERRS - 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    logic [9:0]    s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
    logic          vid_ce_q, vid_ce_d;
    logic [9:0]    vid_data_q, vid_data_d;
    logic          vid_trs_q, vid_trs_d, vid_eav_q, vid_eav_d;
    logic          field_q, field_d, vblank_q, vblank_d;
    logic          hblank_q, hblank_d, active_q, active_d;
    logic [11:0]   sample_cnt_q, sample_cnt_d;
    logic [10:0]   line_cnt_q, line_cnt_d;
    logic          prot_err_q, prot_err_d;
    logic [15:0]   prot_cnt_q, prot_cnt_d;
    state_t        state_q, state_d;
    logic [GW-1:0] good_q, good_d;
    logic [EW-1:0] errs_q, errs_d;

    logic f, v, h;
    logic preamble, prot_ok, trs_hit, prot_fail, eav;
    logic at_last, line_evt, line_good;

    assign f = rx_data[8];
    assign v = rx_data[7];
    assign h = rx_data[6];

    // XYZ is the word arriving now; 3FF 000 000 are already in s2..s0
    assign preamble  = (s2_q == 10'h3FF) && (s1_q == 10'h000)
                    && (s0_q == 10'h000);
    assign prot_ok   = rx_data[9]
                    && (rx_data[5:2] == {v ^ h, f ^ h, f ^ v, f ^ v ^ h});
    assign trs_hit   = rx_ce && preamble && prot_ok;
    assign prot_fail = rx_ce && preamble && !prot_ok;
    assign eav       = trs_hit && h;
    assign at_last   = (sample_cnt_q == LAST_SAMPLE);
    assign line_evt  = rx_ce && (eav || at_last);
    assign line_good = eav && at_last;

    always_comb begin
        s0_d         = s0_q;
        s1_d         = s1_q;
        s2_d         = s2_q;
        vid_ce_d     = rx_ce;
        vid_data_d   = vid_data_q;
        vid_trs_d    = 1'b0;
        vid_eav_d    = 1'b0;
        field_d      = field_q;
        vblank_d     = vblank_q;
        hblank_d     = hblank_q;
        active_d     = active_q;
        sample_cnt_d = sample_cnt_q;
        line_cnt_d   = line_cnt_q;
        prot_err_d   = 1'b0;
        prot_cnt_d   = prot_cnt_q;

        if (rx_ce) begin
            s0_d       = rx_data;
            s1_d       = s0_q;
            s2_d       = s1_q;
            vid_data_d = s2_q;
            if (eav || at_last) begin
                sample_cnt_d = '0;
            end else begin
                sample_cnt_d = sample_cnt_q + 12'd1;
            end
        end

        if (trs_hit) begin
            vid_trs_d = 1'b1;
            vid_eav_d = h;
            field_d   = f;
            vblank_d  = v;
            hblank_d  = h;
            active_d  = ~h & ~v;
        end

        if (prot_fail) begin
            prot_err_d = 1'b1;
            if (prot_cnt_q != 16'hFFFF) begin
                prot_cnt_d = prot_cnt_q + 16'd1;
            end
        end

        // Field 2 -> 1 transition restarts the line count
        if (eav) begin
            if (!f && field_q) begin
                line_cnt_d = '0;
            end else if (line_cnt_q != 11'h7FF) begin
                line_cnt_d = line_cnt_q + 11'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        errs_d  = errs_q;
        if (line_evt) begin
            unique case (state_q)
                HUNT: begin
                    if (eav) begin
                        state_d = VERIFY;
                        good_d  = '0;
                    end
                end
                VERIFY: begin
                    if (!line_good) begin
                        state_d = HUNT;
                    end else if (good_q == GOOD_LAST) begin
                        state_d = LOCKED;
                        errs_d  = '0;
                    end else begin
                        good_d = good_q + 1'b1;
                    end
                end
                LOCKED: begin
                    if (line_good) begin
                        errs_d = '0;
                    end else if (errs_q == ERRS_LAST) begin
                        state_d = HUNT;
                    end else begin
                        errs_d = errs_q + 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge sdi_rx_clk) begin
        if (sdi_rx_rst) begin
            s0_q         <= '0;
            s1_q         <= '0;
            s2_q         <= '0;
            vid_ce_q     <= 1'b0;
            vid_data_q   <= '0;
            vid_trs_q    <= 1'b0;
            vid_eav_q    <= 1'b0;
            field_q      <= 1'b0;
            vblank_q     <= 1'b0;
            hblank_q     <= 1'b0;
            active_q     <= 1'b0;
            sample_cnt_q <= '0;
            line_cnt_q   <= '0;
            prot_err_q   <= 1'b0;
            prot_cnt_q   <= '0;
            state_q      <= HUNT;
            good_q       <= '0;
            errs_q       <= '0;
        end else begin
            s0_q         <= s0_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            vid_ce_q     <= vid_ce_d;
            vid_data_q   <= vid_data_d;
            vid_trs_q    <= vid_trs_d;
            vid_eav_q    <= vid_eav_d;
            field_q      <= field_d;
            vblank_q     <= vblank_d;
            hblank_q     <= hblank_d;
            active_q     <= active_d;
            sample_cnt_q <= sample_cnt_d;
            line_cnt_q   <= line_cnt_d;
            prot_err_q   <= prot_err_d;
            prot_cnt_q   <= prot_cnt_d;
            state_q      <= state_d;
            good_q       <= good_d;
            errs_q       <= errs_d;
        end
    end

    assign vid_ce         = vid_ce_q;
    assign vid_data       = vid_data_q;
    assign vid_trs        = vid_trs_q;
    assign vid_eav        = vid_eav_q;
    assign vid_field      = field_q;
    assign vid_vblank     = vblank_q;
    assign vid_hblank     = hblank_q;
    assign vid_active     = active_q;
    assign sample_cnt     = sample_cnt_q;
    assign line_cnt       = line_cnt_q;
    assign locked         = (state_q == LOCKED);
    assign trs_prot_err   = prot_err_q;
    assign prot_err_count = prot_cnt_q;

endmodule

// File: tb/tb_sdi_rx_trs_decoder.sv
// Directed bench for sdi_rx_trs_decoder: XYZ vector table plus
// multi-line lock, flywheel, gap and reset sequences.
module tb_sdi_rx_trs_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_ce;
    logic [9:0]  rx_data;
    logic        vid_ce;
    logic [9:0]  vid_data;
    logic        vid_trs, vid_eav, vid_field, vid_vblank, vid_hblank, vid_active;
    logic [11:0] sample_cnt;
    logic [10:0] line_cnt;
    logic        locked, trs_prot_err;
    logic [15:0] prot_err_count;

    always #5 clk = ~clk;

    sdi_rx_trs_decoder dut (
        .sdi_rx_clk     (clk),
        .sdi_rx_rst     (rst),
        .rx_ce          (rx_ce),
        .rx_data        (rx_data),
        .vid_ce         (vid_ce),
        .vid_data       (vid_data),
        .vid_trs        (vid_trs),
        .vid_eav        (vid_eav),
        .vid_field      (vid_field),
        .vid_vblank     (vid_vblank),
        .vid_hblank     (vid_hblank),
        .vid_active     (vid_active),
        .sample_cnt     (sample_cnt),
        .line_cnt       (line_cnt),
        .locked         (locked),
        .trs_prot_err   (trs_prot_err),
        .prot_err_count (prot_err_count)
    );

    typedef struct {
        logic [9:0]  xyz;
        int          gap;
        logic [6:0]  flags;
        logic [15:0] cnt;
        logic [10:0] line;
    } vec_t;

    int         checks = 0;
    int         failures = 0;
    int         tally;
    int         fillc = 0;
    logic [9:0] p0, p1, p2;
    vec_t       tbl [10];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_out();
        return 64'({vid_ce, vid_data, vid_trs, vid_eav, vid_field,
                    vid_vblank, vid_hblank, vid_active, sample_cnt,
                    line_cnt, locked, trs_prot_err, prot_err_count});
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        rx_ce = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        p0 = '0;
        p1 = '0;
        p2 = '0;
    endtask

    task automatic idle_cycle();
        rx_ce = 1'b0;
        @(posedge clk);
        #1;
        if (vid_ce !== 1'b0 || vid_trs !== 1'b0 || vid_eav !== 1'b0
            || trs_prot_err !== 1'b0)
            tally++;
    endtask

    task automatic send_word(input logic [9:0] w, input int gap);
        repeat (gap) idle_cycle();
        rx_ce = 1'b1;
        rx_data = w;
        @(posedge clk);
        #1;
        rx_ce = 1'b0;
        if (vid_ce !== 1'b1 || vid_data !== p2)
            tally++;
        p2 = p1;
        p1 = p0;
        p0 = w;
    endtask

    function automatic int pick_gap(input bit gapped);
        if (gapped)
            return int'($urandom_range(0, 2));
        return 0;
    endfunction

    task automatic send_fill(input int n, input bit gapped);
        for (int i = 0; i < n; i++) begin
            send_word(10'h100 | 10'(fillc & 255), pick_gap(gapped));
            fillc++;
            if (vid_trs !== 1'b0 || trs_prot_err !== 1'b0)
                tally++;
        end
    endtask

    task automatic send_trs(input logic [9:0] xyz, input bit gapped,
                            input int fixed_gap);
        logic [9:0] pre [3];
        pre[0] = 10'h3FF;
        pre[1] = 10'h000;
        pre[2] = 10'h000;
        for (int i = 0; i < 3; i++) begin
            send_word(pre[i], gapped ? pick_gap(1'b1) : fixed_gap);
            if (vid_trs !== 1'b0)
                tally++;
        end
        send_word(xyz, gapped ? pick_gap(1'b1) : fixed_gap);
    endtask

    task automatic send_line(input string tag, input int len, input bit with_eav,
                             input bit gapped, input logic exp_lock,
                             input int exp_line);
        tally = 0;
        if (with_eav) begin
            send_trs(10'h274, gapped, 0);
            check({tag, "_eav_flags"},
                  64'({vid_trs, vid_eav, vid_hblank, locked, vid_data}),
                  64'({3'b111, exp_lock, 10'h3FF}));
            check({tag, "_eav_cnt"}, 64'({sample_cnt, line_cnt}),
                  64'({12'd0, 11'(exp_line)}));
            send_fill(len - 4, gapped);
            check({tag, "_end_cnt"}, 64'(sample_cnt), 64'(len - 4));
        end else begin
            send_fill(3, gapped);
            check({tag, "_fly_last"}, 64'(sample_cnt), 64'(1715));
            send_fill(1, gapped);
            check({tag, "_fly_wrap"}, 64'({sample_cnt, locked, line_cnt}),
                  64'({12'd0, exp_lock, 11'(exp_line)}));
            send_fill(len - 4, gapped);
        end
        check({tag, "_stream"}, 64'(tally), 64'(0));
    endtask

    initial begin
        tbl[0] = '{10'h2AC, 0, 7'b1000100, 16'd0, 11'd0};
        tbl[1] = '{10'h2D8, 0, 7'b1100110, 16'd0, 11'd1};
        tbl[2] = '{10'h27C, 0, 7'b0010110, 16'd1, 11'd1};
        tbl[3] = '{10'h31C, 2, 7'b1001001, 16'd1, 11'd1};
        tbl[4] = '{10'h276, 0, 7'b1100010, 16'd1, 11'd0};
        tbl[5] = '{10'h074, 0, 7'b0010010, 16'd2, 11'd0};
        tbl[6] = '{10'h3C4, 0, 7'b1101110, 16'd2, 11'd1};
        tbl[7] = '{10'h200, 0, 7'b1000001, 16'd2, 11'd1};
        tbl[8] = '{10'h369, 1, 7'b1101010, 16'd2, 11'd2};
        tbl[9] = '{10'h3B4, 0, 7'b0011010, 16'd3, 11'd2};

        rst = 1'b1;
        rx_ce = 1'b0;
        rx_data = '0;
        do_reset();
        check("reset_state", all_out(), 64'(0));

        // Clean lines: phase on EAV1, lock on EAV5
        for (int k = 1; k <= 8; k++)
            send_line("clean", 1716, 1'b1, 1'b0, k >= 5, k);

        // Short lines while locked
        send_line("short9", 1715, 1'b1, 1'b0, 1'b1, 9);
        send_line("short10", 1715, 1'b1, 1'b0, 1'b1, 10);
        send_line("short11", 1715, 1'b1, 1'b0, 1'b1, 11);
        send_line("short12", 1716, 1'b1, 1'b0, 1'b0, 12);

        // Relock, then drop EAVs
        for (int k = 13; k <= 17; k++)
            send_line("relock", 1716, 1'b1, 1'b0, k == 17, k);
        send_line("fly1", 1716, 1'b0, 1'b0, 1'b1, 17);
        send_line("fly2", 1716, 1'b0, 1'b0, 1'b1, 17);
        send_line("fly3", 1716, 1'b0, 1'b0, 1'b0, 17);

        // Bad protection in-stream
        tally = 0;
        send_trs(10'h27C, 1'b0, 0);
        check("prot_err_pulse",
              64'({vid_trs, vid_eav, trs_prot_err, vid_hblank, vid_vblank,
                   vid_field, prot_err_count}),
              64'({6'b001100, 16'd1}));
        idle_cycle();
        check("prot_err_clear", 64'({trs_prot_err, prot_err_count}),
              64'({1'b0, 16'd1}));

        // Gapped stream must give the same flags and counts
        do_reset();
        for (int k = 1; k <= 6; k++)
            send_line("gapped", 1716, 1'b1, 1'b1, k >= 5, k);
        tally = 0;
        send_trs(10'h27C, 1'b1, 0);
        send_fill(700, 1'b1);
        check("pre_rst_state", 64'({locked, prot_err_count, tally[7:0]}),
              64'({1'b1, 16'd1, 8'd0}));
        rst = 1'b1;
        rx_ce = 1'b1;
        rx_data = 10'h3FF;
        @(posedge clk);
        #1;
        check("mid_rst_zero", all_out(), 64'(0));
        rst = 1'b0;
        rx_ce = 1'b0;
        p0 = '0;
        p1 = '0;
        p2 = '0;

        // XYZ decode table
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tally = 0;
            send_trs(tbl[i].xyz, 1'b0, tbl[i].gap);
            check($sformatf("tbl%0d_flags", i),
                  64'({vid_trs, vid_eav, trs_prot_err, vid_field, vid_vblank,
                       vid_hblank, vid_active}), 64'(tbl[i].flags));
            check($sformatf("tbl%0d_cnt", i),
                  64'({prot_err_count, line_cnt}),
                  64'({tbl[i].cnt, tbl[i].line}));
            idle_cycle();
            send_fill(2, 1'b0);
            check($sformatf("tbl%0d_pulse", i), 64'(tally), 64'(0));
        end

        // Line counter saturation
        do_reset();
        for (int i = 1; i <= 2050; i++) begin
            send_trs(10'h274, 1'b0, 0);
            if (i == 2046)
                check("line_2046", 64'(line_cnt), 64'(2046));
            if (i == 2047)
                check("line_2047", 64'(line_cnt), 64'(2047));
            if (i == 2050)
                check("line_sat", 64'(line_cnt), 64'(2047));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
